// File: rtl/md_ctrl.sv
// Multiply/divide controller: a fixed-latency HI/LO unit with busy/stall handshake.
// Optional macro MD_CANCEL_EN adds a cancel port that aborts or suppresses operations.
module md_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
`ifdef MD_CANCEL_EN
    ,
    input  logic        cancel
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] MUL_CNT = 4'd4;
    localparam logic [3:0] DIV_CNT = 4'd9;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
    } opnd_t;

    logic [1:0] state;
    logic [3:0] cnt;
    opnd_t      opnd;
    logic       cancel_i;

`ifdef MD_CANCEL_EN
    assign cancel_i = cancel;
`else
    assign cancel_i = 1'b0;
`endif

    assign busy  = (state != S_IDLE);
    assign stall = md_use & (busy | start);

    // One 64-bit multiplier covers both flavours: the low 64 bits of the
    // product of sign- or zero-extended operands are the exact result.
    logic [63:0] a_ext, b_ext, prod;
    assign a_ext = {{32{opnd.sgn & opnd.a[31]}}, opnd.a};
    assign b_ext = {{32{opnd.sgn & opnd.b[31]}}, opnd.b};
    assign prod  = a_ext * b_ext;

    // Signed division via magnitudes avoids tool-dependent signed-divide corners.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, quo_mag, rem_mag, quo, rem;
    assign a_neg   = opnd.sgn & opnd.a[31];
    assign b_neg   = opnd.sgn & opnd.b[31];
    assign a_mag   = a_neg ? -opnd.a : opnd.a;
    assign b_mag   = b_neg ? -opnd.b : opnd.b;
    assign b_div   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign quo_mag = a_mag / b_div;
    assign rem_mag = a_mag % b_div;
    assign quo     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    assign rem     = a_neg ? -rem_mag : rem_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            opnd  <= '0;
        end else if (cancel_i && state != S_IDLE) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !cancel_i) begin
                        case (md_op)
                            3'd0, 3'd1: begin
                                opnd  <= '{a: A, b: B, sgn: ~md_op[0]};
                                state <= S_MUL;
                                cnt   <= MUL_CNT;
                            end
                            3'd2, 3'd3: begin
                                opnd  <= '{a: A, b: B, sgn: ~md_op[0]};
                                state <= S_DIV;
                                cnt   <= DIV_CNT;
                            end
                            3'd4:    HI <= A;
                            3'd5:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        HI    <= prod[63:32];
                        LO    <= prod[31:0];
                        state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Divide by zero burns the full latency but keeps HI/LO.
                        if (opnd.b != 32'd0) begin
                            HI <= rem;
                            LO <= quo;
                        end
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: vector table of operations plus hand sequences
// for stall, reset mid-operation and (under MD_CANCEL_EN) cancel.
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        md_use = 1'b0;
    logic        cancel = 1'b0;
    logic        busy, stall;
    logic [31:0] HI, LO;

    int checks = 0;
    int passes = 0;

    md_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .md_use (md_use),
        .busy   (busy),
        .stall  (stall),
        .HI     (HI),
        .LO     (LO)
`ifdef MD_CANCEL_EN
        ,
        .cancel (cancel)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          nbusy;
    } vec_t;

    vec_t v[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one op, scramble operands after the start edge, then count busy cycles.
    task automatic run_op(input int idx, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int nbusy);
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = ~a ^ 32'h5A5A_0F0F; B = b + 32'd3;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 50) begin
            nbusy++;
            @(negedge clk);
        end
        if (nbusy >= 50) $display("FAIL timeout vec%0d: busy stuck", idx);
    endtask

    initial begin
        int nb;
        v[0]  = '{3'd4, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'h0000_0000, 0};
        v[1]  = '{3'd5, 32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 0};
        v[2]  = '{3'd3, 32'd7,         32'd0,         32'h0000_1234, 32'h0000_5678, 10};
        v[3]  = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
        v[4]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
        v[5]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        v[6]  = '{3'd3, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};
        v[7]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        v[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        v[9]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        v[10] = '{3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 10};
        v[11] = '{3'd6, 32'hDEAD_BEEF, 32'd1,         32'hFFFF_FFFE, 32'h0000_0002, 0};

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(i, v[i].op, v[i].a, v[i].b, nb);
            chk($sformatf("vec%0d_busy", i), nb, v[i].nbusy);
            chk($sformatf("vec%0d_hi", i), HI, v[i].hi);
            chk($sformatf("vec%0d_lo", i), LO, v[i].lo);
        end

        // Stall during busy; a second start mid-operation must be ignored.
        @(negedge clk);
        md_use = 1'b1; start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd4;
        #1;
        chk("stall_on_start", {31'd0, stall}, 32'd1);
        chk("busy_on_start", {31'd0, busy}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin md_op = 3'd3; A = 32'd100; B = 32'd5; end
            #1;
            chk($sformatf("stall_busy%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("stall_cyc%0d", i), {31'd0, stall}, 32'd1);
        end
        @(negedge clk);
        #1;
        chk("stall_done_busy", {31'd0, busy}, 32'd0);
        chk("stall_done_stall", {31'd0, stall}, 32'd0);
        chk("stall_done_hi", HI, 32'd0);
        chk("stall_done_lo", LO, 32'd12);
        @(negedge clk);
        chk("ignored_start", {31'd0, busy}, 32'd0);
        md_use = 1'b0;

        // Reset on the third busy cycle of a mult discards it.
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; A = 32'd9; B = 32'd9;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy3", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        md_use = 1'b1; start = 1'b1; md_op = 3'd0;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        reset = 1'b0; start = 1'b0; md_use = 1'b0;
        chk("rst_prio_start", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("rst_no_write_hi", HI, 32'd0);
        chk("rst_no_write_lo", LO, 32'd0);

`ifdef MD_CANCEL_EN
        run_op(100, 3'd4, 32'h0000_00AA, 32'd0, nb);
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; A = 32'd6; B = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", HI, 32'h0000_00AA);
        chk("cancel_lo", LO, 32'd0);
        start = 1'b1; cancel = 1'b1; md_op = 3'd5; A = 32'h77;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_mtlo_lo", LO, 32'd0);
        chk("cancel_mtlo_busy", {31'd0, busy}, 32'd0);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        run_op(101, 3'd1, 32'd5, 32'd5, nb);
        chk("cancel_idle_busy", nb, 5);
        chk("cancel_idle_lo", LO, 32'd25);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
